// File: rtl/sgd_pkg.sv
// Shared constants, sizing helper and FSM state type for the sequential SGD update path.
package sgd_pkg;

  localparam int Q_W    = 16;
  localparam int FRAC   = 8;
  localparam int PROD_W = 32;

  // Weights (m layers of n x n) followed by biases (n per layer).
  function automatic int total_params(input int n, input int m);
    return m * n * n + n * m;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN1,
    DRAIN2,
    DONE
  } sgd_state_t;

endpackage

// File: rtl/sgd_lane.sv
// Single-element Q8.8 update: p_new = p - (lr*g)[23:8], wrapping, no rounding or saturation.
module sgd_lane
  import sgd_pkg::*;
(
  input  logic signed [Q_W-1:0] p,
  input  logic signed [Q_W-1:0] g,
  input  logic signed [Q_W-1:0] lr,
  output logic signed [Q_W-1:0] p_new
);

  logic signed [PROD_W-1:0] prod;
  logic                     unused_prod_bits;

  always_comb begin
    prod  = lr * g;
    p_new = p - prod[FRAC+Q_W-1:FRAC];
  end

  // Integer overflow bits and truncated fraction are intentionally dropped.
  assign unused_prod_bits = ^{prod[PROD_W-1:FRAC+Q_W], prod[FRAC-1:0]};

endmodule

// File: rtl/sgd_sched.sv
// Sequential SGD update controller: streams every parameter/gradient pair through one lane,
// writes the updated parameter back and clears the consumed gradient.
module sgd_sched
  import sgd_pkg::*;
#(
  parameter int N     = 4,
  parameter int M     = 4,
  parameter int TOTAL = total_params(N, M),
  parameter int AW    = $clog2(TOTAL)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [15:0]   lr,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [AW-1:0]        rd_addr,
  input  logic signed [15:0]   p_rdata,
  input  logic signed [15:0]   g_rdata,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic signed [15:0]   p_wdata,
  output logic                 g_clr,
  output logic [15:0]          step_cnt,
  output sgd_state_t           state
);

  // Protocol: start is a level sampled only in IDLE; done is a single-cycle pulse.
  // Memory read data is expected exactly one cycle after rd_en; there is no backpressure.
  localparam logic [AW-1:0] LAST = AW'(TOTAL - 1);

  sgd_state_t          state_q, state_d;
  logic [AW-1:0]       cnt_q;
  logic signed [15:0]  lr_q;
  logic                v1_q;
  logic [AW-1:0]       a1_q;
  logic signed [15:0]  lane_out;

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    rd_en   = 1'b0;
    rd_addr = cnt_q;
    case (state_q)
      IDLE:   if (start) state_d = RUN;
      RUN: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (cnt_q == LAST) state_d = DRAIN1;
      end
      DRAIN1: begin
        busy    = 1'b1;
        state_d = DRAIN2;
      end
      DRAIN2: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  sgd_lane u_lane (
    .p     (p_rdata),
    .g     (g_rdata),
    .lr    (lr_q),
    .p_new (lane_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      lr_q     <= '0;
      v1_q     <= 1'b0;
      a1_q     <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      p_wdata  <= '0;
      step_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        cnt_q <= '0;
        lr_q  <= lr;
      end else if (state_q == RUN && cnt_q != LAST) begin
        cnt_q <= cnt_q + AW'(1);
      end else if (state_q == DONE) begin
        cnt_q <= '0;
      end
      // Stage 1 tracks the outstanding read; stage 2 registers the lane result.
      v1_q  <= rd_en;
      a1_q  <= rd_addr;
      wr_en <= v1_q;
      if (v1_q) begin
        wr_addr <= a1_q;
        p_wdata <= lane_out;
      end
      if (state_q == DONE) step_cnt <= step_cnt + 16'd1;
    end
  end

  assign g_clr = wr_en;
  assign state = state_q;

endmodule

// File: tb/tb_sgd_sched.sv
// Directed bench for sgd_sched: memory model, expected-write queue, timing and reset checks.
module tb_sgd_sched;
  import sgd_pkg::*;

  localparam int N     = 4;
  localparam int M     = 4;
  localparam int TOTAL = 80;
  localparam int AW    = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [15:0]       lr;
  logic              busy, done, rd_en, wr_en, g_clr;
  logic [AW-1:0]     rd_addr, wr_addr;
  logic [15:0]       p_rdata, g_rdata, p_wdata, step_cnt;
  sgd_state_t        state;

  always #5 clk = ~clk;

  sgd_sched #(.N(N), .M(M)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .lr       (lr),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .p_rdata  (p_rdata),
    .g_rdata  (g_rdata),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .p_wdata  (p_wdata),
    .g_clr    (g_clr),
    .step_cnt (step_cnt),
    .state    (state)
  );

  logic [15:0]    p_mem [TOTAL];
  logic [15:0]    g_mem [TOTAL];
  logic [AW+15:0] exp_q [$];
  int             checks  = 0;
  int             errors  = 0;
  int             cyc     = 0;
  int             nwrites = 0;
  int             t0      = 0;
  bit             rd_pend = 1'b0;
  logic [AW-1:0]  pend_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference update written independently of the RTL lane.
  function automatic logic [15:0] ref_upd(input logic [15:0] p, input logic [15:0] g,
                                          input logic [15:0] l);
    longint prod;
    prod = longint'($signed(l)) * longint'($signed(g));
    return p - prod[23:8];
  endfunction

  task automatic fill_random();
    for (int i = 0; i < TOTAL; i++) begin
      p_mem[i] = 16'($urandom_range(0, 65535));
      g_mem[i] = 16'($urandom_range(0, 65535));
    end
  endtask

  task automatic push_pass(input logic [15:0] l);
    for (int i = 0; i < TOTAL; i++)
      exp_q.push_back({AW'(i), ref_upd(p_mem[i], g_mem[i], l)});
  endtask

  // Advance one cycle; act as the 1R1W memory pair and score any write seen this cycle.
  task automatic tick();
    logic [AW+15:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (rd_pend && pend_addr < TOTAL) begin
      p_rdata = p_mem[pend_addr];
      g_rdata = g_mem[pend_addr];
    end else begin
      p_rdata = 16'h0;
      g_rdata = 16'h0;
    end
    rd_pend   = rd_en;
    pend_addr = rd_addr;
    if (wr_en) begin
      nwrites++;
      chk("g_clr_on_write", 32'(g_clr), 32'd1);
      chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e[AW+15:16]));
        chk("p_wdata", 32'(p_wdata), 32'(e[15:0]));
      end
      if (wr_addr < TOTAL) begin
        p_mem[wr_addr] = p_wdata;
        if (g_clr) g_mem[wr_addr] = 16'h0;
      end
    end else begin
      chk("g_clr_idle", 32'(g_clr), 32'd0);
    end
  endtask

  task automatic start_pass(input logic [15:0] l);
    lr      = l;
    start   = 1'b1;
    t0      = cyc;
    nwrites = 0;
    push_pass(l);
    tick();
    start = 1'b0;
    chk("busy_c1", 32'(busy), 32'd1);
    chk("rd_en_c1", 32'(rd_en), 32'd1);
    chk("rd_addr_c1", 32'(rd_addr), 32'd0);
  endtask

  task automatic wait_done(input int exp_rel, input bit disturb, input string tag);
    int rel;
    bit seen;
    rel  = 0;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      tick();
      rel = cyc - t0;
      if (disturb) begin
        if (rel == 5 || rel == 40) start = 1'b1;
        if (rel == 6 || rel == 41) start = 1'b0;
        if (rel == 10) lr = lr ^ 16'h5A5A;
      end
      if (done) seen = 1'b1;
    end
    chk(tag, 32'(rel), 32'(exp_rel));
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("writes_per_pass", 32'(nwrites), 32'(TOTAL));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic after_done(input logic [15:0] exp_steps);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("step_cnt", 32'(step_cnt), 32'(exp_steps));
  endtask

  initial begin
    int nz;
    rst     = 1'b1;
    start   = 1'b0;
    lr      = 16'h0;
    p_rdata = 16'h0;
    g_rdata = 16'h0;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_p_wdata", 32'(p_wdata), 32'd0);
    chk("rst_step_cnt", 32'(step_cnt), 32'd0);
    chk("rst_state", 32'(state), 32'(IDLE));
    rst = 1'b0;
    tick();

    // Pass A: lr=1.0, random contents with one directed element.
    fill_random();
    p_mem[5] = 16'h0200;
    g_mem[5] = 16'h0080;
    start_pass(16'h0100);
    wait_done(TOTAL + 3, 1'b0, "done_cycle_a");
    chk("single_elem_p", 32'(p_mem[5]), 32'h0180);
    chk("single_elem_g", 32'(g_mem[5]), 32'h0);
    nz = 0;
    for (int i = 0; i < TOTAL; i++) if (g_mem[i] != 16'h0) nz++;
    chk("grads_cleared", 32'(nz), 32'd0);
    after_done(16'd1);

    // Pass B: largest positive lr and gradient against the most negative parameter.
    fill_random();
    p_mem[0] = 16'h8000;
    g_mem[0] = 16'h7FFF;
    start_pass(16'h7FFF);
    wait_done(TOTAL + 3, 1'b0, "done_cycle_b");
    chk("wrap_elem_p", 32'(p_mem[0]), 32'h8100);
    after_done(16'd2);

    // Pass C: negative lr; start pulses and lr change mid-pass must be ignored.
    fill_random();
    p_mem[TOTAL-1] = 16'h0000;
    g_mem[TOTAL-1] = 16'h0100;
    start_pass(16'hFF00);
    wait_done(TOTAL + 3, 1'b1, "done_cycle_c");
    chk("neg_lr_elem_p", 32'(p_mem[TOTAL-1]), 32'h0100);
    after_done(16'd3);
    for (int i = 0; i < 6; i++) tick();
    chk("no_extra_pass_busy", 32'(busy), 32'd0);
    chk("no_extra_pass_rd", 32'(rd_en), 32'd0);

    // Pass D: reset at cycle 20 abandons the pass.
    fill_random();
    start_pass(16'($urandom_range(0, 65535)));
    for (int i = 0; i < 19; i++) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_rd_en", 32'(rd_en), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("mid_rst_p_wdata", 32'(p_wdata), 32'd0);
    chk("mid_rst_step_cnt", 32'(step_cnt), 32'd0);
    chk("mid_rst_state", 32'(state), 32'(IDLE));
    exp_q.delete();
    rst = 1'b0;
    nwrites = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("post_rst_no_writes", 32'(nwrites), 32'd0);

    // Pass E: clean pass over the partially updated memory.
    start_pass(16'($urandom_range(0, 65535)));
    wait_done(TOTAL + 3, 1'b0, "done_cycle_e");
    after_done(16'd1);

    // Back-to-back: start held high for three passes.
    fill_random();
    lr      = 16'($urandom_range(0, 65535));
    start   = 1'b1;
    t0      = cyc;
    nwrites = 0;
    push_pass(lr);
    for (int p = 0; p < 3; p++) begin
      wait_done(TOTAL + 3 + p * (TOTAL + 4), 1'b0, "b2b_done_cycle");
      if (p < 2) begin
        nwrites = 0;
        push_pass(lr);
      end else begin
        start = 1'b0;
      end
      after_done(16'(2 + p));
    end
    for (int i = 0; i < 4; i++) tick();
    chk("b2b_stopped", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
